// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, queue entry layout and load FSM states for the writeback unit
package wb_pkg;
  localparam int REG_W = 3;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic              filled;
  } wb_entry_t;
  typedef enum logic {LD_IDLE, LD_WAIT} ld_state_t;
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: producer/register-file side signals of the writeback unit
interface writeback_unit_if;
  import wb_pkg::*;
  logic              alu_valid;
  logic [REG_W-1:0]  alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              load_start;
  logic [REG_W-1:0]  load_dest;
  logic              load_ready;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic [REG_W-1:0]  query_reg;
  logic              hazard;
  logic              regWrite;
  logic [REG_W-1:0]  writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              load_error;
  modport master (
    output alu_valid, alu_dest, alu_data, load_start, load_dest, mem_ready, mem_data, query_reg,
    input  alu_ready, load_ready, hazard, regWrite, writeRegister, writeData, load_error
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, load_start, load_dest, mem_ready, mem_data, query_reg,
    output alu_ready, load_ready, hazard, regWrite, writeRegister, writeData, load_error
  );
endinterface

// File: rtl/wb_slot_queue.sv
// wb_slot_queue: in-order circular slot buffer with reserve/push at tail, fill by index, pop at head
module wb_slot_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW = $clog2(DEPTH),
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rsv_i,
  input  logic [REG_W-1:0]             rsv_dest_i,
  input  logic                         push_i,
  input  logic [REG_W-1:0]             push_dest_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         fill_i,
  input  logic [IW-1:0]                fill_idx_i,
  input  logic [DATA_W-1:0]            fill_data_i,
  input  logic                         pop_i,
  output logic [REG_W-1:0]             head_dest_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic                         head_filled_o,
  output logic [CW-1:0]                count_o,
  output logic [IW-1:0]                tail_o,
  output logic [DEPTH-1:0][REG_W-1:0]  dests_o,
  output logic [DEPTH-1:0]             occ_o
);
  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d, tail_m;
  logic [CW-1:0]   count_q, count_d;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == DEPTH - 1) ? '0 : i + 1'b1;
  endfunction
  // a reservation takes the tail first so a same-cycle push lands behind it
  always_comb begin
    mem_d = mem_q;
    if (fill_i) begin
      mem_d[fill_idx_i].data = fill_data_i;
      mem_d[fill_idx_i].filled = 1'b1;
    end
    if (rsv_i) mem_d[tail_q] = '{dest: rsv_dest_i, data: '0, filled: 1'b0};
    tail_m = rsv_i ? nxt(tail_q) : tail_q;
    if (push_i) mem_d[tail_m] = '{dest: push_dest_i, data: push_data_i, filled: 1'b1};
    tail_d = push_i ? nxt(tail_m) : tail_m;
    head_d = pop_i ? nxt(head_q) : head_q;
    count_d = count_q + CW'(rsv_i) + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dests_o[i] = mem_q[i].dest;
      occ_o[i] = ((i - int'(head_q) + DEPTH) % DEPTH) < int'(count_q);
    end
  end
  assign head_dest_o = mem_q[head_q].dest;
  assign head_data_o = mem_q[head_q].data;
  assign head_filled_o = (count_q != '0) && mem_q[head_q].filled;
  assign count_o = count_q;
  assign tail_o = tail_q;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: orders ALU and load results into single-port register file writes, with hazard flag.
// WRITEBACK_BYPASS_EN: ALU results skip the queue into the output registers when the queue is empty.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LOAD_TIMEOUT = 15
) (
  input logic              clock,
  input logic              reset,
  writeback_unit_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  logic [REG_W-1:0]            head_dest;
  logic [DATA_W-1:0]           head_data;
  logic                        head_filled;
  logic [CW-1:0]               count;
  logic [IW-1:0]               tail;
  logic [DEPTH-1:0][REG_W-1:0] dests;
  logic [DEPTH-1:0]            occ;
  ld_state_t                   ld_state_q, ld_state_d;
  logic [IW-1:0]               slot_q, slot_d;
  logic [TW-1:0]               wait_q, wait_d;
  logic                        err_q, err_d;
  logic                        we_q, we_d;
  logic [REG_W-1:0]            wr_q, wr_d;
  logic [DATA_W-1:0]           wd_q, wd_d;
  logic                        alu_rdy, load_rdy, alu_acc, load_acc, byp, pop, fill, hz;
  logic [DATA_W-1:0]           fill_data;
  assign alu_rdy = count != CW'(DEPTH);
  assign load_rdy = (ld_state_q == LD_IDLE) && (CW'(DEPTH) - count >= CW'(2));
  assign alu_acc = bus.alu_valid && alu_rdy;
  assign load_acc = bus.load_start && load_rdy;
  assign pop = head_filled;
`ifdef WRITEBACK_BYPASS_EN
  assign byp = alu_acc && (count == '0) && !load_acc;
`else
  assign byp = 1'b0;
`endif
  wb_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clock         (clock),
    .reset         (reset),
    .rsv_i         (load_acc),
    .rsv_dest_i    (bus.load_dest),
    .push_i        (alu_acc && !byp),
    .push_dest_i   (bus.alu_dest),
    .push_data_i   (bus.alu_data),
    .fill_i        (fill),
    .fill_idx_i    (slot_q),
    .fill_data_i   (fill_data),
    .pop_i         (pop),
    .head_dest_o   (head_dest),
    .head_data_o   (head_data),
    .head_filled_o (head_filled),
    .count_o       (count),
    .tail_o        (tail),
    .dests_o       (dests),
    .occ_o         (occ)
  );
  // mem_ready is checked before the timeout so real data wins on the deadline edge
  always_comb begin
    ld_state_d = ld_state_q;
    slot_d = slot_q;
    wait_d = wait_q;
    err_d = err_q;
    fill = 1'b0;
    fill_data = bus.mem_data;
    if (ld_state_q == LD_IDLE) begin
      if (load_acc) begin
        ld_state_d = LD_WAIT;
        slot_d = tail;
        wait_d = '0;
      end
    end else if (bus.mem_ready) begin
      fill = 1'b1;
      ld_state_d = LD_IDLE;
    end else if (wait_q == TW'(LOAD_TIMEOUT)) begin
      fill = 1'b1;
      fill_data = '0;
      err_d = 1'b1;
      ld_state_d = LD_IDLE;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end
  always_comb begin
    we_d = byp || pop;
    wr_d = byp ? bus.alu_dest : pop ? head_dest : wr_q;
    wd_d = byp ? bus.alu_data : pop ? head_data : wd_q;
    hz = we_q && (wr_q == bus.query_reg);
    for (int i = 0; i < DEPTH; i++) hz = hz | (occ[i] && (dests[i] == bus.query_reg));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_state_q <= LD_IDLE;
      slot_q <= '0;
      wait_q <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      wr_q <= '0;
      wd_q <= '0;
    end else begin
      ld_state_q <= ld_state_d;
      slot_q <= slot_d;
      wait_q <= wait_d;
      err_q <= err_d;
      we_q <= we_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
    end
  end
  assign bus.alu_ready = alu_rdy;
  assign bus.load_ready = load_rdy;
  assign bus.hazard = hz;
  assign bus.regWrite = we_q;
  assign bus.writeRegister = wr_q;
  assign bus.writeData = wd_q;
  assign bus.load_error = err_q;
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writer-side counterpart of the CPU register file: collects results from the single-cycle ALU path and from multi-cycle data-memory loads, keeps them in program order in a small slot queue, and drives the register file write port at no more than one write per cycle. It sits between execute/memory and the register file. It also supplies a hazard flag so decode can stall on registers that still have a write in flight.

## Interface
- DEPTH, 4: queue slots; at least 2.
- LOAD_TIMEOUT, 15: cycles in LD_WAIT before a load is forcibly completed.

- clock  in  1  sole clock; all state updates on posedge clock.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_dest  in  3  destination register for the ALU result.
- alu_data  in  8  ALU result.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- load_start  in  1  load issued to data memory.
- load_dest  in  3  destination register for the load.
- load_ready  out  1  load accepted when load_start && load_ready.
- mem_ready  in  1  single-cycle pulse: mem_data is valid.
- mem_data  in  8  load data.
- query_reg  in  3  register checked for a pending write.
- hazard  out  1  combinational; query_reg has a pending write.
- regWrite  out  1  register file write enable (registered).
- writeRegister  out  3  register file write index (registered).
- writeData  out  8  register file write data (registered).
- load_error  out  1  sticky; a load timed out.

## Operation
- Queue entry: {dest[2:0], data[7:0], filled}. Entries are pushed at the tail and popped from the head. Count includes reserved (unfilled) entries.
- alu_ready = free slots >= 1. load_ready = (ld_state == LD_IDLE) && free slots >= 2. Both are computed from registered state only. A pop in the same cycle does not raise either ready.
- An accepted ALU result pushes a filled entry.
- An accepted load pushes a reserved entry (dest = load_dest, filled = 0) and moves the load FSM LD_IDLE -> LD_WAIT. The FSM latches the reserved slot index.
- Same-cycle load and ALU acceptance: the load entry is pushed first (older), then the ALU entry.
- LD_WAIT with mem_ready: write mem_data into the reserved slot, set filled, go to LD_IDLE.
- mem_ready in LD_IDLE is ignored.
- LD_WAIT timeout: the wait counter reaches LOAD_TIMEOUT with no mem_ready. Fill the slot with 8'h00, set load_error, go to LD_IDLE.
- Pop happens when the head entry is filled. The output registers load {1, dest, data}; otherwise regWrite is 0 and writeRegister/writeData hold their values.
- An unfilled head blocks all younger entries, which preserves program order.
- hazard = query_reg matches the dest of any occupied queue entry, filled or reserved, or matches writeRegister while regWrite = 1.

## Timing
- Reset values: regWrite 0, writeRegister 0, writeData 0, load_error 0, queue empty, LD_IDLE, wait counter 0. After reset: alu_ready 1, load_ready 1, hazard 0.
- Reset mid-load drops the pending load. A later mem_ready pulse is ignored.
- ALU push at edge N -> pop at edge N+1 -> regWrite high during cycle N+1 to N+2. Latency is 2 edges.
- Load: mem_ready at edge M fills the slot -> pop at edge M+1, provided the slot is at the head.
- Full: alu_ready 0. Slots become available one cycle after the pop.
- The wait counter resets on entry to LD_WAIT. A timeout fill occurs at the edge where counter == LOAD_TIMEOUT.
- Simultaneous mem_ready and timeout edge: mem_data wins and load_error is not set.

## Configuration
- WRITEBACK_BYPASS_EN defined: if the queue is empty and the ALU push is accepted this cycle, the output registers load the ALU result directly at the push edge and nothing is queued. Latency is 1 edge.
- A load reservation makes the queue non-empty, so bypass cannot reorder writes.
- WRITEBACK_BYPASS_EN undefined: every write goes through the queue. Latency is 2 edges.

## Structure
- Package wb_pkg: wb_entry_t struct, ld_state_t enum {LD_IDLE, LD_WAIT}, REG_W = 3, DATA_W = 8.
- One sub-module, wb_slot_queue:
  - circular buffer with head/tail/count;
  - reserve and push ports;
  - a fill-by-index port;
  - head-filled flag;
  - a per-entry dest vector for the hazard compare.
- writeback_unit contains the load FSM, wait counter, output registers and hazard logic.

## Test plan
- Reset, then alu_valid with dest 3, data 8'h5A -> regWrite 1, writeRegister 3, writeData 8'h5A two edges later (one edge with WRITEBACK_BYPASS_EN). hazard(query 3) stays 1 until the write retires.
- load_start with dest 2, then ALU dest 4 data 8'h11 next cycle, mem_ready with 8'hC3 five cycles later -> write 2 = 8'hC3 first, then 4 = 8'h11. No write of 4 occurs before 2.
- Six back-to-back ALU pushes (DEPTH 4) -> alu_ready drops when the queue is full. All accepted values are written in order and none are lost or duplicated.
- load_start with no mem_ready -> after 15 LD_WAIT cycles, write 8'h00 to the dest and load_error goes to 1. A later mem_ready pulse is ignored.
- load_start and alu_valid in the same cycle with three slots free -> both accepted and the load retires first. With one slot free, load_ready is 0.
- Reset asserted in LD_WAIT -> queue empty, regWrite 0, load_error 0. mem_ready on the next cycle produces no write.
